// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Decimal digits needed to hold any bin_w-bit unsigned value: ceil(bin_w*log10(2)),
   // with log10(2) approximated as 0.30103 in fixed point.
   function automatic int unsigned min_digits(input int unsigned bin_w);
      return (bin_w * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Single BCD digit correction for shift-add-3: digits of 5 or more get +3 before the shift.
module bcd_digit_adj (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   // Add 3 to digits 5..9; results stay within 4 bits (max 12).
   always_comb begin
      o_digit = i_digit;
      if (i_digit >= 4'd5) begin
         o_digit = i_digit + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter: one shift-add-3 step per clock, valid/ready on both sides.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  ovf,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam int unsigned BCD_W = 4 * DIGITS;

   if (DIGITS < min_digits(BIN_W)) begin : g_ovf_reachable
      $info("bin2bcd_seq: DIGITS=%0d is below %0d needed for BIN_W=%0d; ovf can assert",
            DIGITS, min_digits(BIN_W), BIN_W);
   end

   state_t              r_state;
   logic [BIN_W-1:0]    r_shift;
   logic [BCD_W-1:0]    r_bcd;
   logic                r_ovf;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_busy;
   logic [BCD_W-1:0]    w_adj;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_digit (r_bcd[4*gi +: 4]),
         .o_digit (w_adj[4*gi +: 4])
      );
   end

   // Handshake FSM plus the shift/count datapath; all outputs are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_bcd       <= '0;
         r_ovf       <= 1'b0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_shift    <= bin_in;
                  r_bcd      <= '0;
                  r_ovf      <= 1'b0;
                  r_cnt      <= CNT_W'(BIN_W);
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= SHIFT;
               end
            end
            SHIFT: begin
               // The bit pushed out of the top digit is a carry worth 10^DIGITS.
               r_bcd   <= {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
               r_shift <= r_shift << 1;
               r_ovf   <= r_ovf | w_adj[BCD_W-1];
               r_cnt   <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign bcd_out   = r_bcd;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq in three configurations (8/3, 8/2, 16/5).
module tb_bin2bcd_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // DUT A: BIN_W=8, DIGITS=3
   logic        a_iv = 1'b0, a_ir, a_ov, a_or = 1'b1, a_ovf, a_busy;
   logic [7:0]  a_bin = '0;
   logic [11:0] a_bcd;
   // DUT B: BIN_W=8, DIGITS=2
   logic        b_iv = 1'b0, b_ir, b_ov, b_or = 1'b1, b_ovf, b_busy;
   logic [7:0]  b_bin = '0;
   logic [7:0]  b_bcd;
   // DUT C: BIN_W=16, DIGITS=5
   logic        c_iv = 1'b0, c_ir, c_ov, c_or = 1'b1, c_ovf, c_busy;
   logic [15:0] c_bin = '0;
   logic [19:0] c_bcd;

   logic [20:0] q_a[$];
   logic [20:0] q_b[$];
   logic [20:0] q_c[$];

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .bin_in(a_bin),
      .out_valid(a_ov), .out_ready(a_or), .bcd_out(a_bcd), .ovf(a_ovf), .busy(a_busy));
   bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .bin_in(b_bin),
      .out_valid(b_ov), .out_ready(b_or), .bcd_out(b_bcd), .ovf(b_ovf), .busy(b_busy));
   bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
      .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .bin_in(c_bin),
      .out_valid(c_ov), .out_ready(c_or), .bcd_out(c_bcd), .ovf(c_ovf), .busy(c_busy));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timed out waiting for DUT (t=%0t)", name, $time);
   endtask

   // Reference: repeated division, {ovf, 20-bit zero-padded packed BCD}.
   function automatic logic [20:0] ref_bcd(input int unsigned val, input int unsigned nd);
      logic [19:0] b;
      int unsigned v;
      b = '0;
      v = val;
      for (int unsigned d = 0; d < nd; d++) begin
         b[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return {(v != 0), b};
   endfunction

   // Monitors: pop one expectation per output transfer.
   logic [20:0] m_exp_a, m_exp_b, m_exp_c;
   logic        m_bad_a, m_bad_b;

   always @(negedge clk) begin
      if (a_ov && a_or) begin
         if (q_a.size() == 0) begin
            timeout("a_unexpected_output");
         end else begin
            m_exp_a = q_a.pop_front();
            chk("a_result", {a_ovf, 8'h00, a_bcd}, m_exp_a);
            if (!a_ovf) begin
               m_bad_a = 1'b0;
               for (int d = 0; d < 3; d++) if (a_bcd[4*d +: 4] > 4'd9) m_bad_a = 1'b1;
               chk("a_digit_range", m_bad_a, 1'b0);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (b_ov && b_or) begin
         if (q_b.size() == 0) begin
            timeout("b_unexpected_output");
         end else begin
            m_exp_b = q_b.pop_front();
            chk("b_result", {b_ovf, 12'h000, b_bcd}, m_exp_b);
            if (!b_ovf) begin
               m_bad_b = 1'b0;
               for (int d = 0; d < 2; d++) if (b_bcd[4*d +: 4] > 4'd9) m_bad_b = 1'b1;
               chk("b_digit_range", m_bad_b, 1'b0);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (c_ov && c_or) begin
         if (q_c.size() == 0) begin
            timeout("c_unexpected_output");
         end else begin
            m_exp_c = q_c.pop_front();
            chk("c_result", {c_ovf, c_bcd}, m_exp_c);
         end
      end
   end

   // Drivers: present a word, wait for acceptance, push the expectation at the handshake.
   task automatic send_a(input logic [7:0] v, input logic [20:0] e);
      int n = 0;
      a_bin = v;
      a_iv  = 1'b1;
      @(negedge clk);
      while (!a_ir && n < 100) begin @(negedge clk); n++; end
      if (!a_ir) begin timeout("a_send"); a_iv = 1'b0; return; end
      q_a.push_back(e);
      @(posedge clk); #1;
      a_iv = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] v, input logic [20:0] e);
      int n = 0;
      b_bin = v;
      b_iv  = 1'b1;
      @(negedge clk);
      while (!b_ir && n < 100) begin @(negedge clk); n++; end
      if (!b_ir) begin timeout("b_send"); b_iv = 1'b0; return; end
      q_b.push_back(e);
      @(posedge clk); #1;
      b_iv = 1'b0;
   endtask

   task automatic send_c(input logic [15:0] v, input logic [20:0] e);
      int n = 0;
      c_bin = v;
      c_iv  = 1'b1;
      @(negedge clk);
      while (!c_ir && n < 100) begin @(negedge clk); n++; end
      if (!c_ir) begin timeout("c_send"); c_iv = 1'b0; return; end
      q_c.push_back(e);
      @(posedge clk); #1;
      c_iv = 1'b0;
   endtask

   task automatic wait_a_valid(output int n);
      n = 0;
      while (!a_ov && n < 100) begin @(posedge clk); #1; n++; end
   endtask

   task automatic wait_c_valid(output int n);
      n = 0;
      while (!c_ov && n < 100) begin @(posedge clk); #1; n++; end
   endtask

   initial begin
      int n;
      int t_prev, t_now;
      int seen;
      logic [15:0] w   [3];
      logic [20:0] wexp[3];
      w    = '{16'd65535, 16'd12345, 16'd1000};
      wexp = '{21'h065535, 21'h012345, 21'h001000};
      t_prev = 0;

      // Reset values while reset is held
      repeat (2) @(posedge clk);
      #1;
      chk("a_reset_state", {a_ir, a_ov, a_busy, a_ovf, a_bcd}, {1'b1, 1'b0, 1'b0, 1'b0, 12'h000});
      chk("c_reset_state", {c_ir, c_ov, c_busy, c_ovf, c_bcd}, {1'b1, 1'b0, 1'b0, 1'b0, 20'h00000});
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed words and first-result latency
      send_a(8'd255, 21'h000255);
      wait_a_valid(n);
      chk("a_latency_8", n, 8);
      send_a(8'd0,  21'h000000);
      send_a(8'd99, 21'h000099);

      // Backpressure: result holds, extra in_valid pulses are ignored
      n = 0;
      while (q_a.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
      a_or = 1'b0;
      send_a(8'd123, 21'h000123);
      wait_a_valid(n);
      for (int k = 0; k < 5; k++) begin
         chk("a_backpressure_hold", {a_ir, a_ov, a_busy, a_ovf, a_bcd},
             {1'b0, 1'b1, 1'b1, 1'b0, 12'h123});
         a_iv  = (k % 2 == 0);
         a_bin = 8'd77;
         @(posedge clk); #1;
      end
      a_iv = 1'b0;
      a_or = 1'b1;
      @(posedge clk); #1;
      chk("a_drain_to_idle", {a_ir, a_ov, a_busy, a_bcd}, {1'b1, 1'b0, 1'b0, 12'h123});
      repeat (3) @(posedge clk);
      #1;
      chk("a_pulses_ignored", {a_busy, a_ir}, {1'b0, 1'b1});

      // Async reset at SHIFT cycle 3 discards the conversion
      send_a(8'd200, 21'h000200);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("a_async_reset", {a_ir, a_ov, a_busy, a_ovf, a_bcd}, {1'b1, 1'b0, 1'b0, 1'b0, 12'h000});
      q_a.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (12) begin @(posedge clk); #1; if (a_ov) seen = 1; end
      chk("a_no_output_after_reset", seen, 0);
      send_a(8'd42, 21'h000042);

      // Overflow configuration
      send_b(8'd200, 21'h100000);
      send_b(8'd99,  21'h000099);
      send_b(8'd255, 21'h100055);
      send_b(8'd100, 21'h100000);

      // Wide configuration: latency and back-to-back acceptance period
      send_c(16'd65535, 21'h065535);
      wait_c_valid(n);
      chk("c_latency_16", n, 16);
      c_iv = 1'b1;
      for (int i = 0; i < 3; i++) begin
         c_bin = w[i];
         @(negedge clk);
         n = 0;
         while (!c_ir && n < 100) begin @(negedge clk); n++; end
         if (!c_ir) begin
            timeout("c_b2b_accept");
         end else begin
            q_c.push_back(wexp[i]);
            t_now = cyc;
            if (i > 0) chk("c_b2b_period", t_now - t_prev, 18);
            t_prev = t_now;
         end
         @(posedge clk); #1;
      end
      c_iv = 1'b0;

      // Exhaustive 8-bit sweeps against the division model
      for (int v = 0; v < 256; v++) send_a(8'(v), ref_bcd(v, 3));
      for (int v = 0; v < 256; v++) send_b(8'(v), ref_bcd(v, 2));

      n = 0;
      while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk("queues_drained", q_a.size() + q_b.size() + q_c.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
